// File: rtl/pipe_pkg.sv
// Shared widths, bubble encoding and helpers for the inter-stage pipeline register.
// No logic of its own; pure declarations.
// Tnew decrement helper saturates at zero so a ready-now result never wraps.
package pipe_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int TNEW_W_DEF      = 2;
  localparam int STALL_CNT_W_DEF = 16;

  // NOP encoding carried by empty slots.
  localparam logic [31:0] NOP_DATA = 32'h0000_0000;

  // Sideband that travels next to the payload.
  typedef struct packed {
    logic [TNEW_W_DEF-1:0] tnew;
    logic                  regwrite;
  } side_t;

  // Saturating decrement applied once when an instruction is captured.
  function automatic logic [31:0] tnew_dec(input logic [31:0] t);
    return (t == 32'd0) ? 32'd0 : t - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// Single pipeline slot: valid bit, payload and sideband with bubble-on-empty.
// Latency: load visible on the outputs one cycle later.
// Backpressure: contents are held whenever neither load nor drain is asserted.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                TNEW_W      = TNEW_W_DEF,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP_DATA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] d_data,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_regwrite,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TNEW_W-1:0] tnew,
  output logic              regwrite
);

  // Slot update: reset/clear beat load, load beats drain; an empty slot always holds the bubble.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid    <= 1'b0;
      data     <= BUBBLE_DATA;
      tnew     <= '0;
      regwrite <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      data     <= d_data;
      tnew     <= d_tnew;
      regwrite <= d_regwrite;
    end else if (drain) begin
      valid    <= 1'b0;
      data     <= BUBBLE_DATA;
      tnew     <= '0;
      regwrite <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush, bubble forcing, optional skid and stall counter.
// Latency: 1 cycle from input transfer to out_valid when the main slot is empty or draining.
// Backpressure: SKID=1 absorbs one extra word and drops in_ready registered; SKID=0 passes out_ready through.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                TNEW_W      = TNEW_W_DEF,
  parameter int                SKID        = 1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP_DATA),
  parameter int                STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [TNEW_W-1:0]      in_tnew,
  input  logic                   in_regwrite,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [TNEW_W-1:0]      out_tnew,
  output logic                   out_regwrite,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [TNEW_W-1:0] main_tnew;
  logic              main_regwrite;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [TNEW_W-1:0] skid_tnew;
  logic              skid_regwrite;

  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic [TNEW_W-1:0] cap_tnew;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  // Tnew ages by one only when the instruction is captured from upstream.
  assign cap_tnew = TNEW_W'(tnew_dec(32'(in_tnew)));

  // A full skid always holds the next-oldest word, so it takes precedence over the input.
  logic [DATA_W-1:0] main_d_data;
  logic [TNEW_W-1:0] main_d_tnew;
  logic              main_d_regwrite;
  assign main_d_data     = skid_valid ? skid_data     : in_data;
  assign main_d_tnew     = skid_valid ? skid_tnew     : cap_tnew;
  assign main_d_regwrite = skid_valid ? skid_regwrite : in_regwrite;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;

      assign in_ready  = !skid_valid;
      assign main_load = (out_xfer && skid_valid) || (in_xfer && (!main_valid || out_ready));
      assign skid_load = in_xfer && main_valid && !out_ready;

      pipe_entry #(
        .DATA_W      (DATA_W),
        .TNEW_W      (TNEW_W),
        .BUBBLE_DATA (BUBBLE_DATA)
      ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (skid_load),
        .drain      (out_xfer),
        .d_data     (in_data),
        .d_tnew     (cap_tnew),
        .d_regwrite (in_regwrite),
        .valid      (skid_valid),
        .data       (skid_data),
        .tnew       (skid_tnew),
        .regwrite   (skid_regwrite)
      );
    end else begin : g_noskid
      assign in_ready      = !main_valid || out_ready;
      assign main_load     = in_xfer;
      assign skid_valid    = 1'b0;
      assign skid_data     = BUBBLE_DATA;
      assign skid_tnew     = '0;
      assign skid_regwrite = 1'b0;
    end
  endgenerate

  pipe_entry #(
    .DATA_W      (DATA_W),
    .TNEW_W      (TNEW_W),
    .BUBBLE_DATA (BUBBLE_DATA)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .load       (main_load),
    .drain      (out_xfer),
    .d_data     (main_d_data),
    .d_tnew     (main_d_tnew),
    .d_regwrite (main_d_regwrite),
    .valid      (main_valid),
    .data       (main_data),
    .tnew       (main_tnew),
    .regwrite   (main_regwrite)
  );

  assign out_valid    = main_valid;
  assign out_data     = main_data;
  assign out_tnew     = main_tnew;
  assign out_regwrite = main_regwrite && main_valid;

  // Count backpressured cycles, saturating; only reset clears it (flush does not).
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=0 and a SKID=1 instance share one stimulus stream.
// A two-deep FIFO model per instance predicts outputs, checked every negedge.
// Directed literal checks pin the model at the interesting points.
module tb_pipe_stage_reg;

  logic clk;
  logic reset, flush, in_valid, in_regwrite, out_ready;
  logic [31:0] in_data;
  logic [1:0]  in_tnew;

  logic [1:0]        ov, ir, orw;
  logic [1:0][31:0]  od;
  logic [1:0][1:0]   ot;
  logic [1:0][15:0]  sc;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_reg #(.SKID(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_tnew(in_tnew), .in_regwrite(in_regwrite),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_tnew(ot[0]), .out_regwrite(orw[0]), .stall_cnt(sc[0])
  );

  pipe_stage_reg #(.SKID(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_tnew(in_tnew), .in_regwrite(in_regwrite),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_tnew(ot[1]), .out_regwrite(orw[1]), .stall_cnt(sc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Model: per instance an ordered list of up to 2 words (oldest at index 0) plus a stall count.
  logic [31:0] md [2][2];
  logic [1:0]  mt [2][2];
  logic        mr [2][2];
  int          mn [2];
  int          mcnt [2];
  bit          model_ok = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit m_ov, m_ir;
      if (reset) begin
        mn[i]   = 0;
        mcnt[i] = 0;
      end else begin
        m_ov = (mn[i] > 0);
        m_ir = (i == 1) ? (mn[i] < 2) : (mn[i] == 0 || out_ready);
        if (m_ov && !out_ready && mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
        if (flush) begin
          mn[i] = 0;
        end else begin
          if (m_ov && out_ready) begin
            md[i][0] = md[i][1]; mt[i][0] = mt[i][1]; mr[i][0] = mr[i][1];
            mn[i] = mn[i] - 1;
          end
          if (in_valid && m_ir) begin
            md[i][mn[i]] = in_data;
            mt[i][mn[i]] = (in_tnew == 2'd0) ? 2'd0 : in_tnew - 2'd1;
            mr[i][mn[i]] = in_regwrite;
            mn[i] = mn[i] + 1;
          end
        end
      end
    end
    if (reset) model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        bit e_ov, e_ir;
        e_ov = (mn[i] > 0);
        e_ir = (i == 1) ? (mn[i] < 2) : (mn[i] == 0 || out_ready);
        chk($sformatf("u%0d out_valid", i), 32'(ov[i]), 32'(e_ov));
        chk($sformatf("u%0d in_ready", i), 32'(ir[i]), 32'(e_ir));
        chk($sformatf("u%0d out_data", i), od[i], e_ov ? md[i][0] : 32'h0);
        chk($sformatf("u%0d out_tnew", i), 32'(ot[i]), e_ov ? 32'(mt[i][0]) : 32'h0);
        chk($sformatf("u%0d out_regwrite", i), 32'(orw[i]), e_ov ? 32'(mr[i][0]) : 32'h0);
        chk($sformatf("u%0d stall_cnt", i), 32'(sc[i]), 32'(mcnt[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; in_regwrite = 0;
    out_ready = 1; in_data = 32'h0; in_tnew = 2'd0;
    step(); step();
    reset = 0;
    at_neg();
    chk("rst out_valid", 32'(ov[1]), 32'd0);
    chk("rst in_ready", 32'(ir[1]), 32'd1);
    chk("rst stall_cnt", 32'(sc[1]), 32'd0);
    chk("rst out_data", od[1], 32'h0);

    // Basic capture with Tnew decrement
    in_valid = 1; in_data = 32'h1234_5678; in_tnew = 2'd2; in_regwrite = 1; out_ready = 1;
    step();
    in_valid = 0;
    at_neg();
    chk("t1 out_valid", 32'(ov[1]), 32'd1);
    chk("t1 out_data", od[1], 32'h1234_5678);
    chk("t1 out_tnew", 32'(ot[1]), 32'd1);
    chk("t1 out_regwrite", 32'(orw[1]), 32'd1);
    step();

    // Tnew=0 saturates, held 3 cycles under backpressure
    in_valid = 1; in_data = 32'hA5A5_0001; in_tnew = 2'd0; in_regwrite = 0; out_ready = 0;
    step();
    in_valid = 0;
    step(); step(); step();
    at_neg();
    chk("t2 out_tnew", 32'(ot[1]), 32'd0);
    chk("t2 stall_cnt", 32'(sc[1]), 32'd3);
    chk("t2 out_data held", od[1], 32'hA5A5_0001);
    out_ready = 1;
    step();

    // Skid: A then B under backpressure, then drain in order
    out_ready = 0; in_valid = 1; in_data = 32'hAAAA_0001; in_tnew = 2'd3; in_regwrite = 1;
    step();
    in_data = 32'hBBBB_0002; in_tnew = 2'd1; in_regwrite = 0;
    step();
    in_valid = 0;
    at_neg();
    chk("t3 in_ready low", 32'(ir[1]), 32'd0);
    chk("t3 out_data A", od[1], 32'hAAAA_0001);
    chk("t3 out_tnew A", 32'(ot[1]), 32'd2);
    out_ready = 1;
    step();
    at_neg();
    chk("t3 out_data B", od[1], 32'hBBBB_0002);
    chk("t3 out_tnew B", 32'(ot[1]), 32'd0);
    step();
    at_neg();
    chk("t3 empty valid", 32'(ov[1]), 32'd0);
    chk("t3 empty data", od[1], 32'h0);

    // SKID=0: back-to-back replace with no bubble
    in_valid = 1; in_data = 32'hDDDD_0004; in_tnew = 2'd1; in_regwrite = 1; out_ready = 1;
    step();
    in_data = 32'hCCCC_0003; in_tnew = 2'd2;
    at_neg();
    chk("t4 u0 in_ready", 32'(ir[0]), 32'd1);
    chk("t4 u0 out_valid D", 32'(ov[0]), 32'd1);
    step();
    in_valid = 0;
    at_neg();
    chk("t4 u0 out_valid C", 32'(ov[0]), 32'd1);
    chk("t4 u0 out_data C", od[0], 32'hCCCC_0003);
    chk("t4 u0 out_tnew C", 32'(ot[0]), 32'd1);
    step();

    // Flush with both slots full and an incoming word
    out_ready = 0; in_valid = 1; in_data = 32'h1111_0001; in_tnew = 2'd2; in_regwrite = 1;
    step();
    in_data = 32'h2222_0002;
    step();
    in_data = 32'hEEEE_EEEE; flush = 1;
    step();
    flush = 0; in_valid = 0;
    at_neg();
    chk("t5 out_valid", 32'(ov[1]), 32'd0);
    chk("t5 out_regwrite", 32'(orw[1]), 32'd0);
    chk("t5 out_tnew", 32'(ot[1]), 32'd0);
    chk("t5 in_ready", 32'(ir[1]), 32'd1);
    chk("t5 out_data", od[1], 32'h0);
    out_ready = 1;
    step(); step();

    // Stall counter saturation, then reset together with flush
    out_ready = 0; in_valid = 1; in_data = 32'h5555_5555; in_tnew = 2'd1; in_regwrite = 1;
    step();
    in_valid = 0;
    repeat (65536 + 5) step();
    at_neg();
    chk("t6 u1 stall_cnt sat", 32'(sc[1]), 32'h0000_FFFF);
    chk("t6 u0 stall_cnt sat", 32'(sc[0]), 32'h0000_FFFF);
    reset = 1; flush = 1;
    step();
    reset = 0; flush = 0;
    at_neg();
    chk("t6 stall_cnt cleared", 32'(sc[1]), 32'd0);
    chk("t6 out_valid cleared", 32'(ov[1]), 32'd0);
    chk("t6 in_ready", 32'(ir[1]), 32'd1);
    step(); step();
    at_neg();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register; next generation of the fixed-field ID/EX-style latch.
- Payload (instruction, operands, immediate, PC) travels as one packed bus. RegWrite and Tnew travel alongside it.
- Adds valid/ready handshake, synchronous flush, bubble forcing, an optional one-entry skid buffer, and a saturating stall counter.
- Instantiated between every pair of stages: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- DATA_W, 32 — width of packed payload bus.
- TNEW_W, 2 — width of Tnew field.
- SKID, 1 — 1: one-entry skid buffer, registered in_ready. 0: single entry, combinational in_ready.
- BUBBLE_DATA, 0 — payload value presented and stored when an entry is empty (NOP encoding).
- STALL_CNT_W, 16 — width of stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_tnew  in  TNEW_W  Tnew of the instruction as produced upstream.
- in_regwrite  in  1  instruction writes the GPR file.
- out_valid  out  1  main entry occupied.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  main entry payload.
- out_tnew  out  TNEW_W  main entry Tnew.
- out_regwrite  out  1  main entry RegWrite, gated by valid.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- reset (sync, active-high) and clk as above. On reset:
  - main and skid valid=0, data=BUBBLE_DATA, tnew=0, regwrite=0.
  - stall_cnt=0.
  - out_valid=0, in_ready=1 from the next cycle.
- Transfers: input transfer = in_valid&in_ready. Output transfer = out_valid&out_ready. Both are sampled at the rising edge.
- Tnew on capture: stored tnew = (in_tnew==0) ? 0 : in_tnew-1, saturating at 0.
  - Decrement happens once per capture only. Holding an entry, or moving skid->main, does not change tnew.
- Latency: 1 cycle from input transfer to out_valid=1 when main is empty or draining.
- Bubble forcing: whenever an entry is invalid, its data=BUBBLE_DATA, tnew=0, regwrite=0. Outputs therefore never expose stale payload.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - On input transfer, main loads the input.
  - On output transfer without input transfer, main becomes bubble.
- SKID=1, registered in_ready:
  - in_ready = !skid_valid.
  - Main empty or draining, skid empty: input loads main.
  - Main full and not draining: input loads skid.
  - Output transfer with skid full: main<=skid, skid<=bubble. A simultaneous input transfer is impossible (in_ready=0).
  - Order is preserved: main always holds the older instruction.
- flush:
  - Has priority over load and drain. Next cycle main and skid are bubble.
  - Input presented in the flush cycle is discarded even if in_ready=1.
  - stall_cnt is unaffected.
- reset has priority over flush.
- stall_cnt increments when out_valid&!out_ready. It saturates at all-ones and is cleared only by reset.
- Backpressure: while out_ready=0 and the entry is held, out_data, out_tnew and out_regwrite stay stable.

Decomposition:
- Package pipe_pkg holds:
  - default widths;
  - the NOP/bubble constant 32'h0000_0000;
  - a function tnew_dec(tnew) for saturating decrement;
  - a packed struct type for the sideband (tnew, regwrite).
- One natural sub-module, pipe_entry: a single valid+payload+sideband slot with load/clear/bubble behaviour.
  - Instantiated once for main and, under generate when SKID=1, once for skid.

Test Plan:
- Reset, then in_valid=1, in_data=32'h1234_5678, in_tnew=2, in_regwrite=1, out_ready=1 -> next cycle out_valid=1, out_data=32'h1234_5678, out_tnew=1, out_regwrite=1.
- Capture with in_tnew=0 -> out_tnew=0 (no wrap to 3). Hold 3 cycles with out_ready=0 -> out_tnew stays 0, stall_cnt=3.
- SKID=1: A then B sent with out_ready=0 -> in_ready drops to 0 after B; out_data=A. Raise out_ready -> A then B appear on consecutive cycles, then out_valid=0 and out_data=BUBBLE_DATA.
- SKID=0: out_valid=1, out_ready=1, in_valid=1 with C -> in_ready=1 the same cycle; C replaces the current entry with no bubble cycle.
- Flush with main and skid full and in_valid=1 -> next cycle out_valid=0, out_regwrite=0, out_tnew=0, in_ready=1; the incoming word never appears.
- Force out_ready=0 for 2^STALL_CNT_W+5 cycles -> stall_cnt saturates at 16'hFFFF. Assert reset and flush together -> everything clears, stall_cnt=0.
